// File: rtl/csr_unit.sv
// LoongArch CSR file: masked CSR writes, timer, interrupt pending,
// exception entry and ERTN return with front-end redirect.
module csr_unit (
    input  logic        clk,
    input  logic        rstn,
    input  logic [13:0] csr_raddr,
    output logic [31:0] csr_rdata,
    input  logic [13:0] csr_waddr,
    input  logic [31:0] csr_we,
    input  logic [31:0] csr_wdata,
    input  logic        exc_valid,
    input  logic [6:0]  exc_ecode,
    input  logic [31:0] exc_pc,
    input  logic        badv_we,
    input  logic [31:0] badv_in,
    input  logic        ertn_valid,
    input  logic [7:0]  hw_int,
    output logic        int_pending,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [1:0]  crmd_plv,
    output logic        crmd_da
);

    localparam logic [13:0] A_CRMD   = 14'h00;
    localparam logic [13:0] A_PRMD   = 14'h01;
    localparam logic [13:0] A_ECFG   = 14'h04;
    localparam logic [13:0] A_ESTAT  = 14'h05;
    localparam logic [13:0] A_ERA    = 14'h06;
    localparam logic [13:0] A_BADV   = 14'h07;
    localparam logic [13:0] A_EENTRY = 14'h0C;
    localparam logic [13:0] A_SAVE0  = 14'h30;
    localparam logic [13:0] A_SAVE1  = 14'h31;
    localparam logic [13:0] A_SAVE2  = 14'h32;
    localparam logic [13:0] A_SAVE3  = 14'h33;
    localparam logic [13:0] A_TID    = 14'h40;
    localparam logic [13:0] A_TCFG   = 14'h41;
    localparam logic [13:0] A_TVAL   = 14'h42;

    localparam logic [13:0] A_TICLR  = 14'h44;
    localparam logic [31:0] M_CRMD   = 32'h0000_01FF;
    localparam logic [31:0] M_PRMD   = 32'h0000_0007;
    localparam logic [31:0] M_ECFG   = 32'h0000_1BFF;
    localparam logic [31:0] M_ESTAT  = 32'h0000_0003;
    localparam logic [31:0] M_EENTRY = 32'hFFFF_FFC0;
    localparam logic [31:0] M_ALL    = 32'hFFFF_FFFF;

    logic [31:0] crmd, prmd, ecfg, estat, era, badv, eentry;
    logic [31:0] tid, tcfg, tval;
    logic [31:0] save [4];

    logic [31:0] crmd_n, prmd_n, ecfg_n, estat_n, era_n, badv_n;
    logic [31:0] eentry_n, tid_n, tcfg_n, tval_n;
    logic [31:0] save_n [4];

    logic wr, tcfg_wr, ticlr_clr, fire;

    function automatic logic [31:0] mwr(input logic [31:0] old,
                                        input logic [31:0] m,
                                        input logic [31:0] we,
                                        input logic [31:0] d);
        logic [31:0] k;
        k = we & m;
        return (old & ~k) | (d & k);
    endfunction

    // Commit writes are squashed by an exception in the same cycle
    assign wr        = !exc_valid && (csr_we != '0);
    assign tcfg_wr   = wr && (csr_waddr == A_TCFG);
    assign ticlr_clr = wr && (csr_waddr == A_TICLR)
                       && csr_we[0] && csr_wdata[0];
    assign fire      = !tcfg_wr && tcfg[0] && (tval == 32'd1);

    always_comb begin
        crmd_n   = crmd;
        prmd_n   = prmd;
        ecfg_n   = ecfg;
        estat_n  = estat;
        era_n    = era;
        badv_n   = badv;
        eentry_n = eentry;
        tid_n    = tid;
        tcfg_n   = tcfg;
        tval_n   = tval;
        save_n   = save;
        if (wr) begin
            case (csr_waddr)
                A_CRMD:   crmd_n   = mwr(crmd, M_CRMD, csr_we, csr_wdata);
                A_PRMD:   prmd_n   = mwr(prmd, M_PRMD, csr_we, csr_wdata);
                A_ECFG:   ecfg_n   = mwr(ecfg, M_ECFG, csr_we, csr_wdata);
                A_ESTAT:  estat_n  = mwr(estat, M_ESTAT, csr_we, csr_wdata);
                A_ERA:    era_n    = mwr(era, M_ALL, csr_we, csr_wdata);
                A_BADV:   badv_n   = mwr(badv, M_ALL, csr_we, csr_wdata);
                A_EENTRY: eentry_n = mwr(eentry, M_EENTRY, csr_we, csr_wdata);
                A_SAVE0, A_SAVE1, A_SAVE2, A_SAVE3:
                    save_n[csr_waddr[1:0]] =
                        mwr(save[csr_waddr[1:0]], M_ALL, csr_we, csr_wdata);
                A_TID:    tid_n    = mwr(tid, M_ALL, csr_we, csr_wdata);
                A_TCFG:   tcfg_n   = mwr(tcfg, M_ALL, csr_we, csr_wdata);
                default: ;
            endcase
        end

        if (tcfg_wr) begin
            tval_n = {tcfg_n[31:2], 2'b00};
        end else if (tcfg[0] && tval != '0) begin
            tval_n = tval - 32'd1;
        end else if (tcfg[0] && tcfg[1]) begin
            tval_n = {tcfg[31:2], 2'b00};
        end

        // Timer set beats a TICLR clear landing on the same edge
        estat_n[9:2] = hw_int;
        if (fire) begin
            estat_n[11] = 1'b1;
        end else if (ticlr_clr) begin
            estat_n[11] = 1'b0;
        end

        if (exc_valid) begin
            prmd_n[2:0]    = crmd[2:0];
            crmd_n[2:0]    = 3'b000;
            estat_n[21:16] = exc_ecode[5:0];
            estat_n[30:22] = {8'b0, exc_ecode[6]};
            era_n          = exc_pc;
            if (badv_we) begin
                badv_n = badv_in;
            end
        end else if (ertn_valid) begin
            crmd_n[2:0] = prmd[2:0];
            if (estat[21:16] == 6'h3F) begin
                crmd_n[3] = 1'b0;
                crmd_n[4] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crmd   <= 32'h0000_0008;
            prmd   <= '0;
            ecfg   <= '0;
            estat  <= '0;
            era    <= '0;
            badv   <= '0;
            eentry <= '0;
            tid    <= '0;
            tcfg   <= '0;
            tval   <= '0;
            save   <= '{default: '0};
        end else begin
            crmd   <= crmd_n;
            prmd   <= prmd_n;
            ecfg   <= ecfg_n;
            estat  <= estat_n;
            era    <= era_n;
            badv   <= badv_n;
            eentry <= eentry_n;
            tid    <= tid_n;
            tcfg   <= tcfg_n;
            tval   <= tval_n;
            save   <= save_n;
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_raddr)
            A_CRMD:   csr_rdata = crmd;
            A_PRMD:   csr_rdata = prmd;
            A_ECFG:   csr_rdata = ecfg;
            A_ESTAT:  csr_rdata = estat;
            A_ERA:    csr_rdata = era;
            A_BADV:   csr_rdata = badv;
            A_EENTRY: csr_rdata = eentry;
            A_SAVE0, A_SAVE1, A_SAVE2, A_SAVE3:
                csr_rdata = save[csr_raddr[1:0]];
            A_TID:    csr_rdata = tid;
            A_TCFG:   csr_rdata = tcfg;
            A_TVAL:   csr_rdata = tval;
            default:  csr_rdata = '0;
        endcase
    end

    assign int_pending    = crmd[2] & |(estat[12:0] & ecfg[12:0]);
    assign redirect_valid = exc_valid | ertn_valid;
    assign redirect_pc    = exc_valid ? eentry : era;
    assign crmd_plv       = crmd[1:0];
    assign crmd_da        = crmd[3];

endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: directed table, hand sequences for exception,
// ERTN, timer and reset, then randomized run against a reference model.
module tb_csr_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic [13:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic [13:0] csr_waddr;
    logic [31:0] csr_we;
    logic [31:0] csr_wdata;
    logic        exc_valid;
    logic [6:0]  exc_ecode;
    logic [31:0] exc_pc;
    logic        badv_we;
    logic [31:0] badv_in;
    logic        ertn_valid;
    logic [7:0]  hw_int;
    logic        int_pending;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  crmd_plv;
    logic        crmd_da;

    int n_chk = 0;
    int n_fail = 0;

    csr_unit dut (
        .clk(clk), .rstn(rstn),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .csr_waddr(csr_waddr), .csr_we(csr_we), .csr_wdata(csr_wdata),
        .exc_valid(exc_valid), .exc_ecode(exc_ecode), .exc_pc(exc_pc),
        .badv_we(badv_we), .badv_in(badv_in), .ertn_valid(ertn_valid),
        .hw_int(hw_int), .int_pending(int_pending),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .crmd_plv(crmd_plv), .crmd_da(crmd_da)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [13:0] a;
        logic [31:0] we;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [14];
    logic [31:0] mr [0:127];
    logic [31:0] nx [0:127];
    logic [13:0] alist [19];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        csr_we     = '0;
        exc_valid  = 1'b0;
        ertn_valid = 1'b0;
        badv_we    = 1'b0;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] we,
                      input logic [31:0] d);
        csr_waddr = a;
        csr_we    = we;
        csr_wdata = d;
        step();
        csr_we = '0;
    endtask

    task automatic rd(input logic [13:0] a, output logic [31:0] v);
        csr_raddr = a;
        #1;
        v = csr_rdata;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        step();
    endtask

    function automatic logic [31:0] wmask(input logic [13:0] a);
        case (a)
            14'h00: return 32'h0000_01FF;
            14'h01: return 32'h0000_0007;
            14'h04: return 32'h0000_1BFF;
            14'h05: return 32'h0000_0003;
            14'h0C: return 32'hFFFF_FFC0;
            14'h06, 14'h07, 14'h30, 14'h31, 14'h32, 14'h33,
            14'h40, 14'h41: return 32'hFFFF_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] mread(input logic [13:0] a);
        if (wmask(a) != 0 || a == 14'h42) return mr[a[6:0]];
        return 32'h0;
    endfunction

    initial begin
        logic [31:0] v;
        logic        found;
        logic [31:0] tc, tv;
        logic        fire, exp_ip;

        rstn = 1'b0;
        csr_raddr = '0; csr_waddr = '0; csr_wdata = '0;
        exc_ecode = '0; exc_pc = '0; badv_in = '0; hw_int = '0;
        idle();

        tbl[0]  = '{14'h06, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'hFFFF_0000};
        tbl[1]  = '{14'h06, 32'h0000_FFFF, 32'h1234_5678, 32'hFFFF_5678};
        tbl[2]  = '{14'h05, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0003};
        tbl[3]  = '{14'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0007};
        tbl[4]  = '{14'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1BFF};
        tbl[5]  = '{14'h0C, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5640};
        tbl[6]  = '{14'h30, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tbl[7]  = '{14'h33, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'h0F0F_0F0F};
        tbl[8]  = '{14'h40, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
        tbl[9]  = '{14'h42, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[10] = '{14'h44, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        tbl[11] = '{14'h02, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[12] = '{14'h07, 32'h0000_FF00, 32'h1234_ABCD, 32'h0000_AB00};
        tbl[13] = '{14'h00, 32'hFFFF_FFFF, 32'hFFFF_FE15, 32'h0000_0015};

        alist = '{14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h07, 14'h0C,
                  14'h30, 14'h31, 14'h32, 14'h33, 14'h40, 14'h41, 14'h42,
                  14'h44, 14'h02, 14'h03, 14'h45, 14'h1000};

        do_reset();

        // reset state
        for (int i = 0; i < 19; i++) begin
            rd(alist[i], v);
            chk($sformatf("reset_rd_%0h", alist[i]), v,
                alist[i] == 14'h00 ? 32'h8 : 32'h0);
        end
        chk("reset_int_pending", {31'b0, int_pending}, 32'h0);
        chk("reset_redirect", {31'b0, redirect_valid}, 32'h0);

        // masked write table
        for (int i = 0; i < 14; i++) begin
            wr(tbl[i].a, tbl[i].we, tbl[i].d);
            rd(tbl[i].a, v);
            chk($sformatf("tbl_%0d", i), v, tbl[i].exp);
        end

        // no write-to-read bypass
        do_reset();
        csr_raddr = 14'h30;
        csr_waddr = 14'h30;
        csr_we    = '1;
        csr_wdata = 32'h0000_ABCD;
        #1;
        chk("no_bypass_old", csr_rdata, 32'h0);
        step();
        csr_we = '0;
        rd(14'h30, v);
        chk("no_bypass_new", v, 32'h0000_ABCD);

        // ALE exception with a dropped SAVE0 write
        do_reset();
        wr(14'h00, '1, 32'h7);
        wr(14'h0C, '1, 32'h1C00_8000);
        exc_valid = 1'b1; exc_ecode = 7'h09; exc_pc = 32'h1C00_0100;
        badv_we = 1'b1; badv_in = 32'h8000_0003;
        csr_waddr = 14'h30; csr_we = '1; csr_wdata = 32'h1111_2222;
        #1;
        chk("ale_redir_valid", {31'b0, redirect_valid}, 32'h1);
        chk("ale_redir_pc", redirect_pc, 32'h1C00_8000);
        step();
        idle();
        rd(14'h00, v); chk("ale_crmd", {29'b0, v[2:0]}, 32'h0);
        rd(14'h01, v); chk("ale_prmd", {29'b0, v[2:0]}, 32'h7);
        rd(14'h05, v); chk("ale_ecode", {26'b0, v[21:16]}, 32'h09);
        rd(14'h06, v); chk("ale_era", v, 32'h1C00_0100);
        rd(14'h07, v); chk("ale_badv", v, 32'h8000_0003);
        rd(14'h30, v); chk("ale_save0_dropped", v, 32'h0);

        // ERTN returns to pre-update ERA
        ertn_valid = 1'b1;
        #1;
        chk("ertn_redir_valid", {31'b0, redirect_valid}, 32'h1);
        chk("ertn_redir_pc", redirect_pc, 32'h1C00_0100);
        step();
        idle();
        rd(14'h00, v); chk("ertn_crmd", {29'b0, v[2:0]}, 32'h7);
        chk("ertn_plv", {30'b0, crmd_plv}, 32'h3);

        // TLB refill return clears DA, sets PG
        wr(14'h00, '1, 32'hF);
        exc_valid = 1'b1; exc_ecode = 7'h3F; exc_pc = 32'h1C00_0200;
        step();
        idle();
        ertn_valid = 1'b1;
        step();
        idle();
        rd(14'h00, v); chk("refill_crmd", v, 32'h17);
        chk("refill_da", {31'b0, crmd_da}, 32'h0);

        // exception beats a simultaneous ERTN
        exc_valid = 1'b1; ertn_valid = 1'b1; exc_ecode = 7'h01;
        #1;
        chk("both_redir_pc", redirect_pc, 32'h1C00_8000);
        step();
        idle();
        rd(14'h00, v); chk("both_crmd", v, 32'h10);

        // timer, periodic, InitVal=2
        do_reset();
        wr(14'h04, '1, 32'h800);
        wr(14'h00, '1, 32'h4);
        wr(14'h41, '1, 32'hB);
        rd(14'h42, v); chk("tmr_load", v, 32'h8);
        for (int i = 1; i <= 8; i++) begin
            step();
            rd(14'h05, v);
            if (i == 7) begin
                chk("tmr_is11_pre", {31'b0, v[11]}, 32'h0);
                chk("tmr_ip_pre", {31'b0, int_pending}, 32'h0);
            end
            if (i == 8) begin
                chk("tmr_is11_fire", {31'b0, v[11]}, 32'h1);
                chk("tmr_ip_fire", {31'b0, int_pending}, 32'h1);
                rd(14'h42, v); chk("tmr_zero", v, 32'h0);
            end
        end
        step();
        rd(14'h42, v); chk("tmr_reload", v, 32'h8);
        wr(14'h44, '1, 32'h1);
        rd(14'h05, v); chk("ticlr_clear", {31'b0, v[11]}, 32'h0);
        chk("ticlr_ip", {31'b0, int_pending}, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            rd(14'h42, v);
            if (v == 32'h1) found = 1'b1;
            else step();
        end
        chk("tmr_reach_one", {31'b0, found}, 32'h1);
        wr(14'h44, '1, 32'h1);
        rd(14'h05, v); chk("ticlr_vs_fire", {31'b0, v[11]}, 32'h1);

        // hw_int into IS[2], then async reset mid-count
        do_reset();
        wr(14'h04, '1, 32'h4);
        wr(14'h00, '1, 32'h4);
        hw_int = 8'h01;
        step();
        step();
        chk("hwint_ip", {31'b0, int_pending}, 32'h1);
        rd(14'h05, v); chk("hwint_is2", {31'b0, v[2]}, 32'h1);
        wr(14'h41, '1, 32'h101);
        step(); step(); step();
        rd(14'h42, v); chk("tmr_mid", v, 32'hFD);
        #1;
        rstn = 1'b0;
        #1;
        chk("arst_tval", csr_rdata, 32'h0);
        chk("arst_ip", {31'b0, int_pending}, 32'h0);
        chk("arst_da", {31'b0, crmd_da}, 32'h1);
        hw_int = '0;
        @(negedge clk);
        rstn = 1'b1;
        step();

        // randomized run against the model
        do_reset();
        for (int k = 0; k < 128; k++) mr[k] = '0;
        mr[0] = 32'h8;
        for (int c = 0; c < 400; c++) begin
            csr_waddr  = alist[$urandom_range(0, 18)];
            csr_raddr  = alist[$urandom_range(0, 18)];
            csr_we     = $urandom_range(0, 1) ? 32'h0 :
                         ($urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom);
            csr_wdata  = (csr_waddr == 14'h41) ? $urandom_range(0, 63)
                                               : $urandom;
            exc_valid  = ($urandom_range(0, 15) == 0);
            ertn_valid = ($urandom_range(0, 15) == 0);
            exc_ecode  = $urandom_range(0, 3) == 0 ? 7'h3F : 7'($urandom);
            exc_pc     = $urandom;
            badv_we    = 1'($urandom);
            badv_in    = $urandom;
            if ($urandom_range(0, 7) == 0) hw_int = 8'($urandom);
            #1;
            exp_ip = mr[0][2] && ((mr[5][12:0] & mr[4][12:0]) != 0);
            chk("rnd_rdata", csr_rdata, mread(csr_raddr));
            chk("rnd_ip", {31'b0, int_pending}, {31'b0, exp_ip});
            chk("rnd_redir",
                {redirect_valid, 31'b0} ^ redirect_pc,
                {exc_valid | ertn_valid, 31'b0} ^
                (exc_valid ? mr[12] : mr[6]));
            chk("rnd_mode", {29'b0, crmd_da, crmd_plv},
                {29'b0, mr[0][3], mr[0][1:0]});

            nx = mr;
            if (!exc_valid && csr_we != 0 && wmask(csr_waddr) != 0)
                nx[csr_waddr[6:0]] =
                    (mr[csr_waddr[6:0]] & ~(csr_we & wmask(csr_waddr))) |
                    (csr_wdata & csr_we & wmask(csr_waddr));
            tc = mr[65];
            tv = mr[66];
            fire = 1'b0;
            if (!exc_valid && csr_we != 0 && csr_waddr == 14'h41)
                nx[66] = nx[65] & 32'hFFFF_FFFC;
            else if (tc[0] && tv != 0) begin
                nx[66] = tv - 1;
                fire = (tv == 1);
            end else if (tc[0] && tc[1])
                nx[66] = tc & 32'hFFFF_FFFC;
            nx[5][9:2] = hw_int;
            if (fire) nx[5][11] = 1'b1;
            else if (!exc_valid && csr_waddr == 14'h44 &&
                     csr_we[0] && csr_wdata[0]) nx[5][11] = 1'b0;
            if (exc_valid) begin
                nx[1][2:0]   = mr[0][2:0];
                nx[0][2:0]   = 3'b0;
                nx[5][21:16] = exc_ecode[5:0];
                nx[5][30:22] = {8'b0, exc_ecode[6]};
                nx[6]        = exc_pc;
                if (badv_we) nx[7] = badv_in;
            end else if (ertn_valid) begin
                nx[0][2:0] = mr[1][2:0];
                if (mr[5][21:16] == 6'h3F) begin
                    nx[0][3] = 1'b0;
                    nx[0][4] = 1'b1;
                end
            end
            step();
            mr = nx;
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
